tom_wordasm32: RTL and testbench

Word assembler that sits directly upstream of the 32-bit load-enabled sync register in Tom. It takes 16-bit bus writes, holds the high half until the matching low half arrives, then presents the full 32-bit word with a single-cycle load strobe. A pending high half that is never completed is discarded after a programmable timeout and flagged.

---
 rtl/tom_wordasm32.sv | 78 +++++++
 tb/tb_tom_wordasm32.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tom_wordasm32.sv
// rtl/tom_wordasm32.sv - 16-to-32-bit word assembler with high-half hold timeout
// Feeds a load-enabled 32-bit register: high half is held until its low half commits the word.
module tom_wordasm32 #(
  parameter int TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        wr,
  input  logic        hi,
  input  logic        clr,
  output logic [31:0] d,
  output logic        ld,
  output logic        pend,
  output logic        tmo
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

  state_t      state, state_n;
  logic [15:0] hreg, hreg_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] d_n;
  logic        ld_n, tmo_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      hreg  <= '0;
      cnt   <= '0;
      d     <= '0;
      ld    <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      hreg  <= hreg_n;
      cnt   <= cnt_n;
      d     <= d_n;
      ld    <= ld_n;
      tmo   <= tmo_n;
    end
  end

  // clr beats wr beats timeout; a low write always commits, even with nothing held.
  always_comb begin
    state_n = state;
    hreg_n  = hreg;
    cnt_n   = cnt;
    d_n     = d;
    ld_n    = 1'b0;
    tmo_n   = 1'b0;
    if (clr) begin
      state_n = EMPTY;
    end else if (wr) begin
      if (hi) begin
        hreg_n  = din;
        cnt_n   = '0;
        state_n = HELD;
      end else begin
        d_n     = {hreg, din};
        ld_n    = 1'b1;
        state_n = EMPTY;
      end
    end else if (state == HELD) begin
      if (cnt == CNT_LAST) begin
        tmo_n   = 1'b1;
        state_n = EMPTY;
      end else begin
        cnt_n = cnt + 8'd1;
      end
    end
  end

  assign pend = (state == HELD);

endmodule

// File: tb/tb_tom_wordasm32.sv
// tb/tb_tom_wordasm32.sv - scoreboard bench for tom_wordasm32 with TMO=4
module tb_tom_wordasm32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        wr = 1'b0;
  logic        hi = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] d;
  logic        ld, pend, tmo;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  typedef struct {
    bit          is_tmo;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];

  tom_wordasm32 #(.TMO(4)) dut (
    .clk(clk), .rst(rst), .din(din), .wr(wr), .hi(hi), .clr(clr),
    .d(d), .ld(ld), .pend(pend), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Apply one transfer for exactly one cycle; returns 1 ns after the capturing edge.
  task automatic drive(input bit w, input bit h, input bit c, input logic [15:0] v);
    wr = w; hi = h; clr = c; din = v;
    @(posedge clk); #1;
    wr = 1'b0; hi = 1'b0; clr = 1'b0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_commit(input logic [31:0] w);
    exp_t e;
    e.is_tmo = 1'b0;
    e.word   = w;
    exp_q.push_back(e);
  endtask

  task automatic expect_tmo(input logic [31:0] w);
    exp_t e;
    e.is_tmo = 1'b1;
    e.word   = w;
    exp_q.push_back(e);
  endtask

  // Monitor: every ld or tmo pulse must match the front of the expectation queue.
  always @(negedge clk) begin
    if (!done && (ld === 1'b1 || tmo === 1'b1)) begin
      if (ld === 1'b1 && tmo === 1'b1) begin
        check("ld_tmo_together", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check(ld ? "unexpected_ld" : "unexpected_tmo", d, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(ld ? "event_is_commit" : "event_is_tmo", {31'd0, tmo}, {31'd0, e.is_tmo});
        check(ld ? "commit_word" : "tmo_word_held", d, e.word);
      end
    end
  end

  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_d", d, 32'h0);
    check("rst_ld", {31'd0, ld}, 32'd0);
    check("rst_pend", {31'd0, pend}, 32'd0);
    check("rst_tmo", {31'd0, tmo}, 32'd0);
    @(posedge clk); #1;

    // lo write straight after reset uses hreg=0
    expect_commit(32'h0000_5555);
    drive(1, 0, 0, 16'h5555);
    @(negedge clk);
    check("lo_after_rst_pend", {31'd0, pend}, 32'd0);
    @(posedge clk); #1;

    // basic hi then lo
    drive(1, 1, 0, 16'h1234);
    @(negedge clk);
    check("hi_pend", {31'd0, pend}, 32'd1);
    @(posedge clk); #1;
    expect_commit(32'h1234_ABCD);
    drive(1, 0, 0, 16'hABCD);
    @(negedge clk);
    check("commit_pend_clear", {31'd0, pend}, 32'd0);
    @(posedge clk); #1;

    // lo without hi reuses last completed high half
    expect_commit(32'h1234_5555);
    drive(1, 0, 0, 16'h5555);
    idle(1);

    // timeout: pend high for 4 idle cycles, then tmo with d unchanged
    drive(1, 1, 0, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tmo_pend_hold", {31'd0, pend}, 32'd1);
      if (i == 3) expect_tmo(32'h1234_5555);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("tmo_pend_drop", {31'd0, pend}, 32'd0);
    check("tmo_pulse", {31'd0, tmo}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_one_cycle", {31'd0, tmo}, 32'd0);
    @(posedge clk); #1;

    // lo write in the would-be timeout cycle commits instead
    drive(1, 1, 0, 16'hBEEF);
    idle(3);
    expect_commit(32'hBEEF_0042);
    drive(1, 0, 0, 16'h0042);
    idle(3);

    // second hi overwrites the first
    drive(1, 1, 0, 16'h1111);
    drive(1, 1, 0, 16'h2222);
    expect_commit(32'h2222_3333);
    drive(1, 0, 0, 16'h3333);
    idle(1);

    // clr together with lo write drops it
    drive(1, 1, 0, 16'hAAAA);
    drive(1, 0, 1, 16'hBBBB);
    @(negedge clk);
    check("clr_pend", {31'd0, pend}, 32'd0);
    check("clr_d_held", d, 32'h2222_3333);
    check("clr_no_ld", {31'd0, ld}, 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 1, 16'h0);
    // hreg survives clr, so the next lo pairs with 0xAAAA
    expect_commit(32'hAAAA_0007);
    drive(1, 0, 0, 16'h0007);

    // back-to-back low writes
    expect_commit(32'hAAAA_0002);
    drive(1, 0, 0, 16'h0002);
    expect_commit(32'hAAAA_0003);
    drive(1, 0, 0, 16'h0003);
    idle(1);

    // reset while holding
    drive(1, 1, 0, 16'hCAFE);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_d", d, 32'h0);
    check("rst2_pend", {31'd0, pend}, 32'd0);
    check("rst2_ld", {31'd0, ld}, 32'd0);
    @(posedge clk); #1;
    expect_commit(32'h0000_0001);
    drive(1, 0, 0, 16'h0001);
    idle(6);

    check("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
